// File: rtl/alu_pkg.sv
// Shared definitions for the ALU handshake responder and its bench:
// operation codes, responder FSM states and the default operand width.
package alu_pkg;

   typedef enum bit [2:0] {
      no_op  = 3'b000,
      add_op = 3'b001,
      and_op = 3'b010,
      xor_op = 3'b011,
      mul_op = 3'b100,
      rst_op = 3'b111
   } operation_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_MUL   = 2'd2,
      ST_REARM = 2'd3
   } state_t;

   localparam int ALU_DATA_W = 8;

endpackage

// File: rtl/alu_mul_pipe.sv
// Unsigned multiplier pipeline: operand stage p0 plus MUL_LAT-1 product
// stages; the valid chain is cleared asynchronously, the data path is not.
module alu_mul_pipe #(
   parameter int DATA_W  = alu_pkg::ALU_DATA_W,
   parameter int MUL_LAT = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_launch,
   input  logic [DATA_W-1:0]     i_a,
   input  logic [DATA_W-1:0]     i_b,
   output logic                  o_vld,
   output logic [2*DATA_W-1:0]   o_prod
);

   logic [DATA_W-1:0]   r_a_p0;
   logic [DATA_W-1:0]   r_b_p0;
   logic [2*DATA_W-1:0] r_prod_p [1:MUL_LAT-1];
   logic [MUL_LAT-1:0]  r_vld_p;

   // bit k of r_vld_p marks stage k holding a live operation
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vld_p <= '0;
      end else begin
         r_vld_p <= {r_vld_p[MUL_LAT-2:0], i_launch};
      end
   end

   // stage p0 -> p1 multiplies; later stages only delay the product
   always_ff @(posedge clk) begin
      if (i_launch) begin
         r_a_p0 <= i_a;
         r_b_p0 <= i_b;
      end
      r_prod_p[1] <= {{DATA_W{1'b0}}, r_a_p0} * {{DATA_W{1'b0}}, r_b_p0};
      for (int k = 2; k < MUL_LAT; k++) begin
         r_prod_p[k] <= r_prod_p[k-1];
      end
   end

   assign o_vld  = r_vld_p[MUL_LAT-1];
   assign o_prod = r_prod_p[MUL_LAT-1];

endmodule

// File: rtl/alu_op_responder.sv
// DUT-side engine of the A/B/op/start -> done/result handshake: one operation
// per start request, single-cycle logic/add path, pipelined multiply.
module alu_op_responder
   import alu_pkg::*;
#(
   parameter int DATA_W  = ALU_DATA_W,
   parameter int MUL_LAT = 3
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_W-1:0]     A,
   input  logic [DATA_W-1:0]     B,
   input  logic [2:0]            op,
   input  logic                  start,
   output logic                  done,
   output logic [2*DATA_W-1:0]   result,
   output logic                  busy
);

   state_t              r_state, w_state_nxt;
   logic [DATA_W-1:0]   r_a, r_b;
   logic [2:0]          r_op;
   logic [2*DATA_W-1:0] r_result, w_result_nxt;
   logic                r_done, w_done_nxt;
   logic                r_busy, w_busy_nxt;
   logic                w_capture, w_launch;
   logic                w_mul_vld;
   logic [2*DATA_W-1:0] w_mul_prod;

   function automatic logic [2*DATA_W-1:0] alu_calc(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b,
                                                     input logic [2:0]        o);
      logic [DATA_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      case (o)
         add_op:  alu_calc = {{(DATA_W-1){1'b0}}, sum};
         and_op:  alu_calc = {{DATA_W{1'b0}}, a & b};
         xor_op:  alu_calc = {{DATA_W{1'b0}}, a ^ b};
         default: alu_calc = '0;
      endcase
   endfunction

   alu_mul_pipe #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) u_mul (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_launch (w_launch),
      .i_a      (A),
      .i_b      (B),
      .o_vld    (w_mul_vld),
      .o_prod   (w_mul_prod)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_result_nxt = r_result;
      w_done_nxt   = 1'b0;
      w_busy_nxt   = r_busy;
      w_capture    = 1'b0;
      w_launch     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // codes outside the four real operations are dropped silently
            if (start && (op == add_op || op == and_op || op == xor_op)) begin
               w_capture   = 1'b1;
               w_busy_nxt  = 1'b1;
               w_state_nxt = ST_EXEC;
            end else if (start && op == mul_op) begin
               w_capture   = 1'b1;
               w_launch    = 1'b1;
               w_busy_nxt  = 1'b1;
               w_state_nxt = ST_MUL;
            end
         end
         ST_EXEC: begin
            w_result_nxt = alu_calc(r_a, r_b, r_op);
            w_done_nxt   = 1'b1;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = start ? ST_REARM : ST_IDLE;
         end
         ST_MUL: begin
            if (w_mul_vld) begin
               w_result_nxt = w_mul_prod;
               w_done_nxt   = 1'b1;
               w_busy_nxt   = 1'b0;
               w_state_nxt  = start ? ST_REARM : ST_IDLE;
            end
         end
         ST_REARM: begin
            if (!start) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_result <= '0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_result <= w_result_nxt;
         r_done   <= w_done_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   // operand capture regs carry data only, so they need no reset
   always_ff @(posedge clk) begin
      if (w_capture) begin
         r_a  <= A;
         r_b  <= B;
         r_op <= op;
      end
   end

   assign done   = r_done;
   assign busy   = r_busy;
   assign result = r_result;

endmodule

// File: tb/tb_alu_op_responder.sv
// Directed and soak bench for alu_op_responder: vector table of single
// operations plus hand sequences for hold, abort, re-arm and random ops.
module tb_alu_op_responder;
   import alu_pkg::*;

   localparam int DW  = 8;
   localparam int LAT = 3;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic [DW-1:0]   A = '0;
   logic [DW-1:0]   B = '0;
   logic [2:0]      op = 3'b000;
   logic            start = 1'b0;
   logic            done;
   logic [2*DW-1:0] result;
   logic            busy;

   int vec_cnt = 0;
   int err_cnt = 0;
   int mon_err = 0;
   logic prev_done = 1'b0;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [2:0]  o;
      logic [15:0] exp;
      int          lat;
      bit          scr;
   } vec_t;

   vec_t tbl[12];

   alu_op_responder #(.DATA_W(DW), .MUL_LAT(LAT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .A       (A),
      .B       (B),
      .op      (op),
      .start   (start),
      .done    (done),
      .result  (result),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset_n) begin
         if (done && busy) begin
            mon_err <= mon_err + 1;
            $display("FAIL done_busy_overlap: done=%b busy=%b at %0t", done, busy, $time);
         end
         if (done && prev_done) begin
            mon_err <= mon_err + 1;
            $display("FAIL done_two_cycles at %0t", $time);
         end
      end
      prev_done <= done;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] o);
      case (o)
         3'b001:  return 16'(a) + 16'(b);
         3'b010:  return 16'(a & b);
         3'b011:  return 16'(a ^ b);
         3'b100:  return 16'(a) * 16'(b);
         default: return 16'h0000;
      endcase
   endfunction

   // One handshake: drive, check busy after capture, wait for done, release start.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                         input logic [15:0] exp, input int lat, input bit scr,
                         input string name);
      int cyc;
      @(negedge clk);
      A = a; B = b; op = o; start = 1'b1;
      @(posedge clk); #1;
      chk({name, "_busy"}, {31'd0, busy}, 32'd1);
      if (scr) begin
         @(negedge clk);
         A = 8'h00; B = 8'h00; op = 3'b010; start = 1'b0;
      end
      cyc = 0;
      while (!done && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({name, "_lat"}, 32'(cyc), 32'(lat));
      chk({name, "_res"}, {16'd0, result}, {16'd0, exp});
      chk({name, "_busy_off"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      start = 1'b0;
      op = 3'b000;
      @(posedge clk); #1;
      chk({name, "_done_off"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      int pulses;
      logic [7:0]  ra, rb;
      logic [2:0]  ro;
      logic [2:0]  ign_codes[4];

      tbl[0]  = '{8'hFF, 8'hFF, 3'b001, 16'h01FE, 1,   1'b0};
      tbl[1]  = '{8'hFF, 8'hFF, 3'b100, 16'hFE01, LAT, 1'b1};
      tbl[2]  = '{8'hF0, 8'h3C, 3'b010, 16'h0030, 1,   1'b0};
      tbl[3]  = '{8'hF0, 8'h3C, 3'b011, 16'h00CC, 1,   1'b0};
      tbl[4]  = '{8'h80, 8'h80, 3'b001, 16'h0100, 1,   1'b0};
      tbl[5]  = '{8'h12, 8'h34, 3'b100, 16'h03A8, LAT, 1'b0};
      tbl[6]  = '{8'h00, 8'hFF, 3'b100, 16'h0000, LAT, 1'b0};
      tbl[7]  = '{8'hFF, 8'h0F, 3'b011, 16'h00F0, 1,   1'b1};
      tbl[8]  = '{8'hAA, 8'hFF, 3'b010, 16'h00AA, 1,   1'b0};
      tbl[9]  = '{8'h10, 8'h10, 3'b100, 16'h0100, LAT, 1'b0};
      tbl[10] = '{8'h7F, 8'h01, 3'b001, 16'h0080, 1,   1'b0};
      tbl[11] = '{8'hF0, 8'h3C, 3'b011, 16'h00CC, 1,   1'b0};

      ign_codes[0] = 3'b000;
      ign_codes[1] = 3'b111;
      ign_codes[2] = 3'b101;
      ign_codes[3] = 3'b110;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_result", {16'd0, result}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].o, tbl[i].exp, tbl[i].lat, tbl[i].scr,
                $sformatf("vec%0d", i));
      end

      // ignored codes: no capture, no done, result holds 00CC
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         A = 8'h55; B = 8'h66; op = ign_codes[c]; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         pulses = 0;
         for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
         end
         chk($sformatf("ignore%0d_nodone", c), 32'(pulses), 32'd0);
         chk($sformatf("ignore%0d_hold", c), {16'd0, result}, 32'h0000_00CC);
      end

      // abort an in-flight multiply with reset one cycle after capture
      @(negedge clk);
      A = 8'h12; B = 8'h34; op = 3'b100; start = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_busy_off", {31'd0, busy}, 32'd0);
      chk("abort_result", {16'd0, result}, 32'd0);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      chk("abort_nodone", 32'(pulses), 32'd0);
      run_op(8'h01, 8'h02, 3'b001, 16'h0003, 1, 1'b0, "post_abort");

      // start held high for 8 cycles gives exactly one operation
      @(negedge clk);
      A = 8'h03; B = 8'h04; op = 3'b001; start = 1'b1;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      chk("rearm_pulses", 32'(pulses), 32'd1);
      chk("rearm_result", {16'd0, result}, 32'h0000_0007);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      run_op(8'hF0, 8'hFF, 3'b011, 16'h000F, 1, 1'b0, "rearm_second");

      // random soak, operands biased to the 00/FF corners
      for (int n = 0; n < 1000; n++) begin
         case ($urandom_range(0, 3))
            0:       ra = 8'h00;
            1:       ra = 8'hFF;
            default: ra = 8'($urandom_range(0, 255));
         endcase
         case ($urandom_range(0, 3))
            0:       rb = 8'h00;
            1:       rb = 8'hFF;
            default: rb = 8'($urandom_range(0, 255));
         endcase
         ro = 3'($urandom_range(1, 4));
         run_op(ra, rb, ro, model(ra, rb, ro), (ro == 3'b100) ? LAT : 1,
                1'($urandom_range(0, 1)), $sformatf("soak%0d", n));
      end

      @(negedge clk);
      chk("protocol_monitor", 32'(mon_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
